// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART program loader.
//   ISA_WIDTH      : width of one memory word (four UART bytes)
//   ROM_DEPTH      : log2 of words per memory; the loader address has one
//                    extra MSB selecting instruction (0) or data (1) memory
//   uart_st_e      : receiver FSM state encodings (UART_ST_*)
package uart_loader_pkg;

    localparam int ISA_WIDTH      = 32;
    localparam int ROM_DEPTH      = 3;
    localparam int ADDR_W         = ROM_DEPTH + 1;
    localparam int BYTES_PER_WORD = ISA_WIDTH / 8;

    typedef enum logic [1:0] {
        UART_ST_IDLE  = 2'd0,
        UART_ST_START = 2'd1,
        UART_ST_DATA  = 2'd2,
        UART_ST_STOP  = 2'd3
    } uart_st_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver with a 2-flop input synchroniser.
//   clk, rst_n     : clock, async active-low reset
//   i_clear        : return receiver to idle (session restart)
//   i_enable       : a new start bit is accepted only while high
//   i_rx           : raw asynchronous serial line, idle high
//   o_byte         : last received byte, valid with o_byte_valid
//   o_byte_valid   : one-cycle pulse, byte with good stop bit
//   o_frame_err    : one-cycle pulse, stop bit sampled low
//   o_start_edge   : one-cycle pulse, start edge accepted
module uart_rx_byte
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clear,
    input  logic       i_enable,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err,
    output logic       o_start_edge
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]       r_sync;
    logic             r_rx_prev;
    uart_st_e         r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_bit, w_bit_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic [7:0]       r_byte, w_byte_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_ferr, w_ferr_nxt;
    logic             w_rx, w_fall;

    assign w_rx   = r_sync[1];
    assign w_fall = r_rx_prev & ~w_rx;

    // Synchroniser and edge-detect flops reset high so reset release
    // cannot look like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[0], i_rx};
            r_rx_prev <= w_rx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= UART_ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_byte  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_byte  <= w_byte_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_byte_nxt  = r_byte;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        case (r_state)
            UART_ST_IDLE: begin
                w_cnt_nxt = '0;
                if (i_enable && w_fall) w_state_nxt = UART_ST_START;
            end
            UART_ST_START: begin
                // Mid-bit check: line back high means it was only a glitch.
                if (r_cnt == HALF_LAST) begin
                    w_cnt_nxt = '0;
                    w_bit_nxt = '0;
                    w_state_nxt = w_rx ? UART_ST_IDLE : UART_ST_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            UART_ST_DATA: begin
                if (r_cnt == FULL_LAST) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_rx, r_shift[7:1]};   // LSB first
                    if (r_bit == 3'd7) w_state_nxt = UART_ST_STOP;
                    else               w_bit_nxt   = r_bit + 3'd1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            UART_ST_STOP: begin
                if (r_cnt == FULL_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = UART_ST_IDLE;
                    if (w_rx) begin
                        w_valid_nxt = 1'b1;
                        w_byte_nxt  = r_shift;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = UART_ST_IDLE;
        endcase
        if (i_clear) begin
            w_state_nxt = UART_ST_IDLE;
            w_cnt_nxt   = '0;
            w_bit_nxt   = '0;
            w_valid_nxt = 1'b0;
            w_ferr_nxt  = 1'b0;
        end
    end

    assign o_byte       = r_byte;
    assign o_byte_valid = r_valid;
    assign o_frame_err  = r_ferr;
    assign o_start_edge = (r_state == UART_ST_IDLE) & i_enable & w_fall & ~i_clear;

endmodule

// File: rtl/uart_loader.sv
// UART program loader: packs received bytes little-endian into words and
// writes them to sequential addresses of instruction then data memory.
//   clk, rst_n        : clock, async active-low reset
//   uart_start        : one-cycle pulse arming (or restarting) a session
//   uart_rx           : serial line, 8N1, idle high
//   uart_write_enable : one-cycle word write strobe
//   uart_data         : assembled word, valid with the strobe
//   uart_addr         : word address, MSB selects data memory
//   uart_active       : session armed or receiving
//   uart_done         : one-cycle pulse at session end
//   uart_frame_err    : sticky framing error, cleared by uart_start
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int IDLE_TIMEOUT = 100000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_start,
    input  logic                 uart_rx,
    output logic                 uart_write_enable,
    output logic [ISA_WIDTH-1:0] uart_data,
    output logic [ROM_DEPTH:0]   uart_addr,
    output logic                 uart_active,
    output logic                 uart_done,
    output logic                 uart_frame_err
);

    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
    localparam int BCNT_W = $clog2(BYTES_PER_WORD);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    logic                 r_active, r_we, r_done, r_ferr, r_seen;
    logic [ADDR_W-1:0]    r_addr;
    logic [BCNT_W-1:0]    r_byte_cnt;
    logic [ISA_WIDTH-1:0] r_word, r_data;
    logic [IDLE_W-1:0]    r_idle_cnt;

    logic [7:0] w_byte;
    logic       w_byte_valid, w_frame_err, w_start_edge;
    logic       w_byte_ok, w_timeout, w_last_wr, w_end;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (uart_start),
        .i_enable     (r_active),
        .i_rx         (uart_rx),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_frame_err  (w_frame_err),
        .o_start_edge (w_start_edge)
    );

    assign w_byte_ok = w_byte_valid & r_active;
    // A byte arriving restarts the idle count, so a timeout can only line up
    // with a strobe already on the bus; done then follows in the next cycle.
    assign w_timeout = r_seen & (r_idle_cnt == IDLE_LAST) & ~w_start_edge & ~w_byte_ok;
    assign w_last_wr = r_we & (r_addr == ADDR_LAST);
    assign w_end     = r_active & (w_timeout | w_last_wr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active   <= 1'b0;
            r_we       <= 1'b0;
            r_done     <= 1'b0;
            r_ferr     <= 1'b0;
            r_seen     <= 1'b0;
            r_addr     <= '0;
            r_byte_cnt <= '0;
            r_word     <= '0;
            r_data     <= '0;
            r_idle_cnt <= '0;
        end else if (uart_start) begin
            r_active   <= 1'b1;
            r_we       <= 1'b0;
            r_done     <= 1'b0;
            r_ferr     <= 1'b0;
            r_seen     <= 1'b0;
            r_addr     <= '0;
            r_byte_cnt <= '0;
            r_word     <= '0;
            r_idle_cnt <= '0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            if (w_frame_err && r_active) r_ferr <= 1'b1;
            // Address advances after each strobe but never wraps.
            if (r_we && !w_last_wr) r_addr <= r_addr + ADDR_W'(1);
            if (w_end) begin
                r_active   <= 1'b0;
                r_done     <= 1'b1;
                r_seen     <= 1'b0;
                r_byte_cnt <= '0;         // partial word is dropped
                r_idle_cnt <= '0;
            end else if (r_active) begin
                if (w_byte_ok) begin
                    r_seen     <= 1'b1;
                    r_idle_cnt <= '0;
                    if (r_byte_cnt == BCNT_LAST) begin
                        r_we       <= 1'b1;
                        r_data     <= {w_byte, r_word[ISA_WIDTH-9:0]};
                        r_byte_cnt <= '0;
                    end else begin
                        r_word[{r_byte_cnt, 3'b000} +: 8] <= w_byte;
                        r_byte_cnt <= r_byte_cnt + BCNT_W'(1);
                    end
                end else if (w_start_edge) begin
                    r_idle_cnt <= '0;
                end else if (r_seen) begin
                    r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
                end
            end
        end
    end

    assign uart_write_enable = r_we;
    assign uart_data         = r_data;
    assign uart_addr         = r_addr;
    assign uart_active       = r_active;
    assign uart_done         = r_done;
    assign uart_frame_err    = r_ferr;

endmodule

// File: tb/tb_uart_loader.sv
module tb_uart_loader;
    import uart_loader_pkg::*;

    localparam int CPB    = 4;
    localparam int TO     = 64;
    localparam int NWORDS = 2 ** (ROM_DEPTH + 1);

    logic                 clk, rst_n, uart_start, uart_rx;
    logic                 uart_write_enable, uart_active, uart_done, uart_frame_err;
    logic [ISA_WIDTH-1:0] uart_data;
    logic [ROM_DEPTH:0]   uart_addr;

    uart_loader #(.CLKS_PER_BIT(CPB), .IDLE_TIMEOUT(TO)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .uart_start        (uart_start),
        .uart_rx           (uart_rx),
        .uart_write_enable (uart_write_enable),
        .uart_data         (uart_data),
        .uart_addr         (uart_addr),
        .uart_active       (uart_active),
        .uart_done         (uart_done),
        .uart_frame_err    (uart_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  n_cmp = 0, n_bad = 0;
    longint cyc = 0, last_we_cyc = 0, done_cyc = 0;
    int  n_done = 0;
    logic [ROM_DEPTH:0]   wr_addr_q[$];
    logic [ISA_WIDTH-1:0] wr_data_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the write/done outputs mid-cycle.
    always @(negedge clk) begin
        if (uart_write_enable) begin
            wr_addr_q.push_back(uart_addr);
            wr_data_q.push_back(uart_data);
            last_we_cyc <= cyc;
        end
        if (uart_done) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0; tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i]; tick(CPB);
        end
        uart_rx = stop_bit; tick(CPB);
        uart_rx = 1'b1; tick(2);
    endtask

    task automatic send_all(input logic [7:0] bq[$]);
        foreach (bq[i]) send_byte(bq[i], 1'b1);
    endtask

    task automatic start_session();
        uart_start = 1'b1; tick(1);
        uart_start = 1'b0;
    endtask

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    // Reference: byte stream -> words, little-endian, addresses 0.., capped
    // at the memory size; any trailing partial word produces no write.
    task automatic check_writes(input string tag, input logic [7:0] bq[$]);
        int nw;
        logic [ISA_WIDTH-1:0] w;
        nw = bq.size() / 4;
        if (nw > NWORDS) nw = NWORDS;
        chk({tag, "_nwr"}, 64'(wr_addr_q.size()), 64'(nw));
        for (int i = 0; i < nw && i < wr_addr_q.size(); i++) begin
            w = {bq[4*i+3], bq[4*i+2], bq[4*i+1], bq[4*i]};
            chk({tag, "_addr"}, 64'(wr_addr_q[i]), 64'(i));
            chk({tag, "_data"}, 64'(wr_data_q[i]), 64'(w));
        end
    endtask

    task automatic wait_done(input string tag, input int base, input int bound);
        for (int i = 0; i < bound && n_done == base; i++) tick(1);
        chk({tag, "_done"}, 64'(n_done - base), 64'd1);
    endtask

    task automatic rand_bytes(input int n, output logic [7:0] bq[$]);
        bq.delete();
        for (int i = 0; i < n; i++) bq.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] bq[$];
        int base, n;

        rst_n = 1'b0; uart_start = 1'b0; uart_rx = 1'b1;
        tick(3);
        chk("rst_we",     64'(uart_write_enable), 0);
        chk("rst_data",   64'(uart_data), 0);
        chk("rst_addr",   64'(uart_addr), 0);
        chk("rst_active", 64'(uart_active), 0);
        chk("rst_done",   64'(uart_done), 0);
        chk("rst_ferr",   64'(uart_frame_err), 0);
        rst_n = 1'b1; tick(2);

        // Single known word.
        clear_mon(); base = n_done;
        start_session();
        chk("w1_active", 64'(uart_active), 1);
        bq = '{8'h78, 8'h56, 8'h34, 8'h12};
        send_all(bq); tick(2);
        check_writes("w1", bq);
        chk("w1_addr_next", 64'(uart_addr), 1);
        chk("w1_still_active", 64'(uart_active), 1);

        // Partial trailing word then idle timeout: 6 bytes, then random lengths.
        for (int t = 0; t < 3; t++) begin
            n = (t == 0) ? 6 : 4 * $urandom_range(1, 3) + $urandom_range(1, 3);
            rand_bytes(n, bq);
            clear_mon(); base = n_done;
            start_session();
            send_all(bq);
            chk("to_no_early_done", 64'(n_done - base), 0);
            wait_done("to", base, TO + 40);
            tick(2);
            check_writes("to", bq);
            chk("to_active", 64'(uart_active), 0);
        end

        // Bytes while inactive are ignored.
        clear_mon();
        rand_bytes(4, bq);
        send_all(bq); tick(4);
        chk("inact_nwr", 64'(wr_addr_q.size()), 0);
        chk("inact_active", 64'(uart_active), 0);

        // Fill both memories: session ends right after the last address.
        rand_bytes(4 * NWORDS, bq);
        clear_mon(); base = n_done;
        start_session();
        send_all(bq);
        wait_done("full", base, 20);
        tick(2);
        check_writes("full", bq);
        chk("full_done_timing", 64'(done_cyc - last_we_cyc), 1);
        chk("full_active", 64'(uart_active), 0);
        chk("full_one_done", 64'(n_done - base), 1);

        // Framing error: byte discarded, flag sticky, next word at addr 0.
        clear_mon(); base = n_done;
        start_session();
        send_byte(8'hA5, 1'b0);
        chk("ferr_set", 64'(uart_frame_err), 1);
        rand_bytes(4, bq);
        send_all(bq); tick(2);
        check_writes("ferr", bq);
        chk("ferr_sticky", 64'(uart_frame_err), 1);
        start_session();
        chk("ferr_cleared", 64'(uart_frame_err), 0);

        // Two-cycle glitch: no byte and no error.
        clear_mon();
        uart_rx = 1'b0; tick(2);
        uart_rx = 1'b1; tick(30);
        chk("glitch_ferr", 64'(uart_frame_err), 0);
        chk("glitch_nwr", 64'(wr_addr_q.size()), 0);
        rand_bytes(4, bq);
        send_all(bq); tick(2);
        check_writes("glitch", bq);

        // Reset mid-session: outputs clear, no strobe, no done.
        clear_mon(); base = n_done;
        start_session();
        rand_bytes(2, bq);
        send_all(bq);
        rst_n = 1'b0; tick(1);
        chk("mrst_we",     64'(uart_write_enable), 0);
        chk("mrst_data",   64'(uart_data), 0);
        chk("mrst_addr",   64'(uart_addr), 0);
        chk("mrst_active", 64'(uart_active), 0);
        tick(TO + 20);
        rst_n = 1'b1; tick(2);
        chk("mrst_nwr",  64'(wr_addr_q.size()), 0);
        chk("mrst_done", 64'(n_done - base), 0);
        start_session();
        rand_bytes(4, bq);
        send_all(bq); tick(2);
        check_writes("mrst", bq);

        // Restart mid-word: the earlier bytes are forgotten.
        clear_mon();
        start_session();
        rand_bytes(3, bq);
        send_all(bq);
        start_session();
        rand_bytes(4, bq);
        send_all(bq); tick(2);
        check_writes("restart", bq);
        chk("restart_addr", 64'(uart_addr), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
